// File: rtl/div_pkg.sv
// Shared types and constants for the iterative 2N/N restoring divider.
// Signed support is compiled in only when DIV_SIGNED_EN is defined.
package div_pkg;

    localparam int DIV_N            = 32;
    localparam int DIV_LAT_UNSIGNED = DIV_N + 1;
    localparam int DIV_LAT_TRAP     = 1;
    localparam int DIV_LAT_SIGNED   = DIV_N + 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_NEG_IN  = 3'd1,
        S_ITER    = 3'd2,
        S_NEG_OUT = 3'd3,
        S_DONE    = 3'd4
    } div_state_e;

    function automatic logic [2*DIV_N-1:0] abs_dividend(input logic [2*DIV_N-1:0] x);
        return x[2*DIV_N-1] ? -x : x;
    endfunction

    function automatic logic [DIV_N-1:0] abs_divisor(input logic [DIV_N-1:0] x);
        return x[DIV_N-1] ? -x : x;
    endfunction

endpackage

// File: rtl/div_sub_step.sv
// One restoring-division step: shift {R,Q} left, then subtract the divisor
// from R when that does not borrow.
module adder_Nbit #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

module div_sub_step
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic [N:0]   r_in,
    input  logic [N-1:0] q_in,
    input  logic [N-1:0] divisor,
    output logic [N:0]   r_out,
    output logic [N-1:0] q_out
);
    logic [N:0] r_sh;
    logic [N:0] diff;
    logic       no_borrow;

    // R stays below the divisor between steps, so its top bit is always clear
    // and only the lower N bits feed the shift.
    logic unused_r_msb;
    assign unused_r_msb = r_in[N];

    assign r_sh = {r_in[N-1:0], q_in[N-1]};

    adder_Nbit #(.W(N + 1)) u_sub (
        .a    (r_sh),
        .b    (~{1'b0, divisor}),
        .cin  (1'b1),
        .sum  (diff),
        .cout (no_borrow)
    );

    assign r_out = no_borrow ? diff : r_sh;
    assign q_out = {q_in[N-2:0], no_borrow};
endmodule

// File: rtl/iterative_divider_64_32.sv
// 64/32 restoring divider, one quotient bit per clock, with early
// divide-by-zero and overflow traps. Optional signed mode: DIV_SIGNED_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start; traps resolve straight to S_DONE
// S_NEG_IN  | operands replaced by their magnitudes (signed only)
// S_ITER    | one shift/subtract per cycle, N cycles
// S_NEG_OUT | result signs restored, signed overflow flagged (signed only)
// S_DONE    | done pulse; results held until next accept
module iterative_divider_64_32
    import div_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_op,
    input  logic [2*DIV_N-1:0] dividend,
    input  logic [DIV_N-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [DIV_N-1:0]   quotient,
    output logic [DIV_N-1:0]   remainder,
    output logic               ovf,
    output logic               dbz
);
    localparam int N  = DIV_N;
    localparam int CW = $clog2(N);

    div_state_e    state, state_nxt;
    logic [CW-1:0] cnt;
    logic [N:0]    r_reg, r_step;
    logic [N-1:0]  q_reg, q_step, d_reg;
    logic          div_zero, hi_ge, last_iter;
    logic          sel_signed, signed_run;

    assign div_zero  = (divisor == '0);
    assign last_iter = (cnt == CW'(N - 1));

`ifdef DIV_SIGNED_EN
    logic           neg_q, neg_r, q_too_big;
    logic [2*N-1:0] in_mag;
    logic [N-1:0]   in_dv_mag;

    assign sel_signed = signed_op;
    assign in_mag     = signed_op ? abs_dividend(dividend) : dividend;
    assign in_dv_mag  = signed_op ? abs_divisor(divisor) : divisor;
    assign hi_ge      = (in_mag[2*N-1:N] >= in_dv_mag);

    // A negative result may reach -2^(N-1); a positive one only 2^(N-1)-1.
    assign q_too_big = neg_q ? (q_reg[N-1] && (q_reg[N-2:0] != '0)) : q_reg[N-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            signed_run <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
        end else if (state == S_IDLE && start) begin
            signed_run <= signed_op;
            neg_q      <= signed_op & (dividend[2*N-1] ^ divisor[N-1]);
            neg_r      <= signed_op & dividend[2*N-1];
        end
    end
`else
    logic unused_signed_op;
    assign unused_signed_op = signed_op;
    assign sel_signed       = 1'b0;
    assign signed_run       = 1'b0;
    assign hi_ge            = (dividend[2*N-1:N] >= divisor);
`endif

    div_sub_step #(.N(N)) u_step (
        .r_in    (r_reg),
        .q_in    (q_reg),
        .divisor (d_reg),
        .r_out   (r_step),
        .q_out   (q_step)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (div_zero || hi_ge) state_nxt = S_DONE;
                    else if (sel_signed)   state_nxt = S_NEG_IN;
                    else                   state_nxt = S_ITER;
                end
            end
            S_NEG_IN:  state_nxt = S_ITER;
            S_ITER:    if (last_iter) state_nxt = signed_run ? S_NEG_OUT : S_DONE;
            S_NEG_OUT: state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            r_reg     <= '0;
            q_reg     <= '0;
            d_reg     <= '0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        r_reg <= {1'b0, dividend[2*N-1:N]};
                        q_reg <= dividend[N-1:0];
                        d_reg <= divisor;
                        dbz   <= div_zero;
                        ovf   <= !div_zero && hi_ge;
                        if (div_zero || hi_ge) begin
                            quotient  <= '1;
                            remainder <= dividend[N-1:0];
                        end
                    end
                end
`ifdef DIV_SIGNED_EN
                S_NEG_IN: begin
                    {r_reg, q_reg} <= {1'b0, abs_dividend({r_reg[N-1:0], q_reg})};
                    d_reg          <= abs_divisor(d_reg);
                end
                S_NEG_OUT: begin
                    quotient  <= neg_q ? -q_reg : q_reg;
                    remainder <= neg_r ? -r_reg[N-1:0] : r_reg[N-1:0];
                    ovf       <= q_too_big;
                end
`endif
                S_ITER: begin
                    r_reg <= r_step;
                    q_reg <= q_step;
                    cnt   <= cnt + CW'(1);
                    if (last_iter && !signed_run) begin
                        quotient  <= q_step;
                        remainder <= r_step[N-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_iterative_divider_64_32.sv
// Self-checking bench for iterative_divider_64_32: directed table, multi-cycle
// corner sequences and randomized operands against an arithmetic model.
module tb_iterative_divider_64_32;
    import div_pkg::*;

`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        ovf;
        logic        dbz;
        int          lat;
    } res_t;

    typedef struct {
        logic [63:0] dd;
        logic [31:0] dv;
        bit          sgn;
        logic [31:0] q;
        logic [31:0] r;
        logic        ovf;
        logic        dbz;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, start, signed_op;
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic        busy, done, ovf, dbz;
    logic [31:0] quotient, remainder;

    int total = 0;
    int bad   = 0;

    iterative_divider_64_32 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_op (signed_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Truncating division computed with plain arithmetic on magnitudes.
    function automatic res_t model(input logic [63:0] dd, input logic [31:0] dv, input bit sgn);
        res_t        m;
        logic [63:0] ma, mb, qm, rm;
        bit          s, negq;
        s     = sgn & SIGNED_EN;
        ma    = dd;
        mb    = {32'b0, dv};
        m.ovf = 1'b0;
        m.dbz = 1'b0;
        if (s && dd[63]) ma = -dd;
        if (s && dv[31]) mb = {32'b0, -dv};
        if (dv == 32'd0) begin
            m.dbz = 1'b1;
            m.q   = '1;
            m.r   = dd[31:0];
            m.lat = DIV_LAT_TRAP;
        end else if (ma / mb > 64'hFFFF_FFFF) begin
            m.ovf = 1'b1;
            m.q   = '1;
            m.r   = dd[31:0];
            m.lat = DIV_LAT_TRAP;
        end else begin
            qm    = ma / mb;
            rm    = ma % mb;
            m.q   = qm[31:0];
            m.r   = rm[31:0];
            m.lat = s ? DIV_LAT_SIGNED : DIV_LAT_UNSIGNED;
            if (s) begin
                negq  = dd[63] ^ dv[31];
                if (negq)   m.q = -qm[31:0];
                if (dd[63]) m.r = -rm[31:0];
                m.ovf = negq ? (qm > 64'h8000_0000) : (qm > 64'h7FFF_FFFF);
            end
        end
        return m;
    endfunction

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic run_op(input logic [63:0] dd, input logic [31:0] dv, input bit sgn,
                          output res_t got, output int busy_cycles);
        int cyc;
        wait_idle();
        dividend  = dd;
        divisor   = dv;
        signed_op = sgn;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        cyc         = 1;
        busy_cycles = 0;
        got.lat     = -1;
        while (cyc <= 100) begin
            if (busy) busy_cycles++;
            if (done) begin
                got.lat = cyc;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        got.q   = quotient;
        got.r   = remainder;
        got.ovf = ovf;
        got.dbz = dbz;
    endtask

    task automatic check_op(input string tag, input logic [63:0] dd, input logic [31:0] dv,
                            input bit sgn, input res_t exp);
        res_t got;
        int   bc;
        run_op(dd, dv, sgn, got, bc);
        chk({tag, ".q"},    {32'b0, got.q}, {32'b0, exp.q});
        chk({tag, ".r"},    {32'b0, got.r}, {32'b0, exp.r});
        chk({tag, ".ovf"},  {63'b0, got.ovf}, {63'b0, exp.ovf});
        chk({tag, ".dbz"},  {63'b0, got.dbz}, {63'b0, exp.dbz});
        chk({tag, ".lat"},  64'(got.lat), 64'(exp.lat));
        chk({tag, ".busy"}, 64'(bc), 64'(exp.lat));
    endtask

    vec_t vecs[$];

    initial begin
        res_t        e;
        logic [63:0] dd;
        logic [31:0] dv, dvm;
        bit          sgn;
        int          t0, t1, cyc, dcount;

        vecs.push_back('{64'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, 33});
        vecs.push_back('{64'h0000_0000_FFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'd15, 1'b0, 1'b0, 33});
        vecs.push_back('{64'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b0, 1'b1, 1});
        vecs.push_back('{64'h0000_0005_0000_0000, 32'd5, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1});
        vecs.push_back('{64'h0000_0004_FFFF_FFFF, 32'd5, 1'b0, 32'hFFFF_FFFF, 32'd4, 1'b0, 1'b0, 33});
        vecs.push_back('{64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 33});
        vecs.push_back('{64'd0, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 33});
`ifdef DIV_SIGNED_EN
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, 35});
        vecs.push_back('{64'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 1'b0, 35});
        vecs.push_back('{64'hFFFF_FFFF_8000_0000, 32'd1, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 35});
`else
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1, 1'b0, 1});
        vecs.push_back('{64'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 1'b0, 33});
`endif

        rst       = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy", {63'b0, busy}, 64'd0);
        chk("reset.done", {63'b0, done}, 64'd0);
        chk("reset.q",    {32'b0, quotient}, 64'd0);
        chk("reset.r",    {32'b0, remainder}, 64'd0);
        chk("reset.ovf",  {63'b0, ovf}, 64'd0);
        chk("reset.dbz",  {63'b0, dbz}, 64'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            e = '{vecs[i].q, vecs[i].r, vecs[i].ovf, vecs[i].dbz, vecs[i].lat};
            check_op($sformatf("vec%0d", i), vecs[i].dd, vecs[i].dv, vecs[i].sgn, e);
        end

        // Results must hold after done until the next accept.
        check_op("hold", 64'd100, 32'd7, 1'b0, '{32'd14, 32'd2, 1'b0, 1'b0, 33});
        repeat (4) @(posedge clk);
        #1;
        chk("hold.q", {32'b0, quotient}, 64'd14);
        chk("hold.r", {32'b0, remainder}, 64'd2);

        // start held high throughout: ignored while busy, re-accepted in IDLE.
        wait_idle();
        dividend  = 64'd100;
        divisor   = 32'd7;
        signed_op = 1'b0;
        start     = 1'b1;
        t0        = -1;
        t1        = -1;
        cyc       = 0;
        while (cyc < 150 && t1 < 0) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                if (t0 < 0) t0 = cyc;
                else        t1 = cyc;
            end
        end
        start = 1'b0;
        chk("b2b.first_done",  64'(t0), 64'd33);
        chk("b2b.second_done", 64'(t1), 64'd67);
        chk("b2b.q",           {32'b0, quotient}, 64'd14);

        // Reset in cycle 10 abandons the division silently.
        wait_idle();
        dividend = 64'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid.busy", {63'b0, busy}, 64'd0);
        chk("rst_mid.done", {63'b0, done}, 64'd0);
        chk("rst_mid.q",    {32'b0, quotient}, 64'd0);
        chk("rst_mid.r",    {32'b0, remainder}, 64'd0);
        chk("rst_mid.ovf",  {63'b0, ovf}, 64'd0);
        chk("rst_mid.dbz",  {63'b0, dbz}, 64'd0);
        rst    = 1'b0;
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        chk("rst_mid.no_done", 64'(dcount), 64'd0);
        check_op("after_rst", 64'd100, 32'd7, 1'b0, '{32'd14, 32'd2, 1'b0, 1'b0, 33});

        for (int i = 0; i < 60; i++) begin
            dv = $urandom;
            case ($urandom_range(0, 7))
                0:       dv = 32'd0;
                1, 2:    dv = 32'($urandom_range(1, 1000));
                default: ;
            endcase
            dd = {32'($urandom), 32'($urandom)};
            if (dv != 32'd0 && $urandom_range(0, 3) != 0) dd[63:32] = dd[63:32] % dv;
            sgn = 1'($urandom_range(0, 1));
            if (sgn && dv != 32'd0 && $urandom_range(0, 3) != 0) begin
                dvm = dv[31] ? -dv : dv;
                dd  = {32'($urandom) % dvm, 32'($urandom)};
                if ($urandom_range(0, 1) == 1) dd = -dd;
            end
            check_op($sformatf("rnd%0d", i), dd, dv, sgn, model(dd, dv, sgn));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
